prog_lut: RTL

PROG_LUT -- requirements
Module: prog_lut

---
 rtl/prog_lut.sv | 80 ++++++++
 1 files changed

// File: rtl/prog_lut.sv
// Programmable lookup table: loaded as a DEPTH-entry stream, then indexed by sel.
// Latency: lookup result registered one cycle after sel_valid; load_done one cycle after the final write.
// Backpressure: load_ready is high only while loading; lookups issued during a load are dropped.
module prog_lut #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [OUT_W-1:0] load_data,
    output logic             load_ready,
    output logic             load_done,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] o,
    output logic             o_valid
);
    localparam int DEPTH = 2 ** SEL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] wr_cnt;
    logic [OUT_W-1:0] lut_mem [DEPTH];

    assign load_ready = (state == LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            o         <= '0;
            o_valid   <= 1'b0;
            load_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                lut_mem[i] <= '0;
            end
        end else begin
            o_valid   <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    // A lookup issued alongside load_start still reads the old table.
                    if (sel_valid) begin
                        o       <= lut_mem[sel];
                        o_valid <= 1'b1;
                    end
                    if (load_start) begin
                        state  <= LOAD;
                        wr_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wr_cnt <= '0;
                    end else if (load_valid) begin
                        lut_mem[wr_cnt] <= load_data;
                        // Final entry leaves LOAD rather than wrapping the counter.
                        if (wr_cnt == '1) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    wr_cnt <= '0;
                end
            endcase
        end
    end
endmodule
